// File: rtl/pm_perf_pkg.sv
// Shared types for the power-management performance monitor.
package pm_perf_pkg;

  typedef enum logic [1:0] {
    PmActive = 2'b00,
    PmIdle   = 2'b01,
    PmSleep  = 2'b10,
    PmOff    = 2'b11
  } pm_state_e;

  typedef enum logic [2:0] {
    SelActCyc     = 3'd0,
    SelIdleCyc    = 3'd1,
    SelSleepCyc   = 3'd2,
    SelOffCyc     = 3'd3,
    SelSleepEntry = 3'd4,
    SelWake       = 3'd5
  } cnt_sel_e;

  localparam int unsigned NUM_CNT = 6;

endpackage

// File: rtl/pm_sat_counter.sv
// Single event counter with selectable saturate/wrap arithmetic and a sticky overflow flag.
module pm_sat_counter #(
  parameter int unsigned CW  = 32,
  parameter bit          SAT = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          ovf
);

  logic [CW-1:0] cnt_d, cnt_q;
  logic          ovf_d, ovf_q;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc) begin
      if (&cnt_q) begin
        // Increment blocked (saturate) or wrapping: either way the event was lost.
        ovf_d = 1'b1;
        cnt_d = SAT ? cnt_q : '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/pm_perf_monitor.sv
// Per-peripheral residency / transition counters with an atomic snapshot bank and read port.
module pm_perf_monitor
  import pm_perf_pkg::*;
#(
  parameter int unsigned  N   = 4,
  parameter int unsigned  CW  = 32,
  parameter bit           SAT = 1'b1,
  localparam int unsigned PW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [2*N-1:0] state,
  input  logic           en,
  input  logic           clr,
  input  logic           snap,
  input  logic           rd_en,
  input  logic [PW-1:0]  rd_peri,
  input  logic [2:0]     rd_sel,
  output logic [CW-1:0]  rd_data,
  output logic           rd_ovf,
  output logic           rd_valid,
  output logic           rd_err,
  output logic           ovf_any
);

  logic [CW-1:0] live_cnt [N][NUM_CNT];
  logic          live_ovf [N][NUM_CNT];
  logic [CW-1:0] sh_cnt_q [N][NUM_CNT];
  logic          sh_ovf_q [N][NUM_CNT];
  pm_state_e     prev_q   [N];

  logic [CW-1:0] rd_data_d, rd_data_q;
  logic          rd_ovf_d, rd_ovf_q;
  logic          rd_hit;
  logic          rd_valid_q, rd_err_q;
  logic          ovf_any_d, ovf_any_q;

  for (genvar i = 0; i < N; i++) begin : g_peri
    pm_state_e            cur;
    logic [NUM_CNT-1:0]   inc;

    assign cur = pm_state_e'(state[2*i +: 2]);

    always_comb begin
      inc = '0;
      if (en) begin
        inc[cur]           = 1'b1;
        inc[SelSleepEntry] = (cur == PmSleep) && (prev_q[i] != PmSleep);
        inc[SelWake]       = (cur == PmActive) &&
                             ((prev_q[i] == PmSleep) || (prev_q[i] == PmOff));
      end
    end

    for (genvar c = 0; c < NUM_CNT; c++) begin : g_cnt
      pm_sat_counter #(
        .CW  (CW),
        .SAT (SAT)
      ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (inc[c]),
        .cnt   (live_cnt[i][c]),
        .ovf   (live_ovf[i][c])
      );
    end
  end

  always_comb begin
    ovf_any_d = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      for (int unsigned c = 0; c < NUM_CNT; c++) begin
        ovf_any_d = ovf_any_d | live_ovf[i][c];
      end
    end
  end

  // Out-of-range requests still get a response, flagged as an error with zero data.
  always_comb begin
    rd_hit    = (32'(rd_peri) < N) && (rd_sel < 3'(NUM_CNT));
    rd_data_d = '0;
    rd_ovf_d  = 1'b0;
    if (rd_hit) begin
      rd_data_d = sh_cnt_q[rd_peri][rd_sel];
      rd_ovf_d  = sh_ovf_q[rd_peri][rd_sel];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N; i++) begin
        prev_q[i] <= PmActive;
        for (int unsigned c = 0; c < NUM_CNT; c++) begin
          sh_cnt_q[i][c] <= '0;
          sh_ovf_q[i][c] <= 1'b0;
        end
      end
      rd_data_q  <= '0;
      rd_ovf_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      ovf_any_q  <= 1'b0;
    end else begin
      // Tracked even while disabled so re-enabling never sees a stale transition.
      for (int unsigned i = 0; i < N; i++) begin
        prev_q[i] <= pm_state_e'(state[2*i +: 2]);
      end
      if (snap) begin
        for (int unsigned i = 0; i < N; i++) begin
          for (int unsigned c = 0; c < NUM_CNT; c++) begin
            sh_cnt_q[i][c] <= live_cnt[i][c];
            sh_ovf_q[i][c] <= live_ovf[i][c];
          end
        end
      end
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd_data_q <= rd_data_d;
        rd_ovf_q  <= rd_ovf_d;
        rd_err_q  <= !rd_hit;
      end
      ovf_any_q <= ovf_any_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_ovf   = rd_ovf_q;
  assign rd_valid = rd_valid_q;
  assign rd_err   = rd_err_q;
  assign ovf_any  = ovf_any_q;

endmodule

// File: tb/tb_pm_perf_monitor.sv
// Bench for pm_perf_monitor: a saturating N=4 instance and a wrapping N=5 instance share stimulus.
module tb_pm_perf_monitor;

  localparam int unsigned CW   = 8;
  localparam longint      MAXV = (64'd1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, en, clr, snap, rd_en;
  logic [7:0] st;
  logic [2:0] rd_peri, rd_sel;

  logic [CW-1:0] a_rd_data, b_rd_data;
  logic          a_rd_ovf, a_rd_valid, a_rd_err, a_ovf_any;
  logic          b_rd_ovf, b_rd_valid, b_rd_err, b_ovf_any;

  pm_perf_monitor #(.N(4), .CW(CW), .SAT(1'b1)) u_dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .state    (st),
    .en       (en),
    .clr      (clr),
    .snap     (snap),
    .rd_en    (rd_en),
    .rd_peri  (rd_peri[1:0]),
    .rd_sel   (rd_sel),
    .rd_data  (a_rd_data),
    .rd_ovf   (a_rd_ovf),
    .rd_valid (a_rd_valid),
    .rd_err   (a_rd_err),
    .ovf_any  (a_ovf_any)
  );

  pm_perf_monitor #(.N(5), .CW(CW), .SAT(1'b0)) u_dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .state    ({2'b00, st}),
    .en       (en),
    .clr      (clr),
    .snap     (snap),
    .rd_en    (rd_en),
    .rd_peri  (rd_peri),
    .rd_sel   (rd_sel),
    .rd_data  (b_rd_data),
    .rd_ovf   (b_rd_ovf),
    .rd_valid (b_rd_valid),
    .rd_err   (b_rd_err),
    .ovf_any  (b_ovf_any)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Reference model: index 0 = saturating N=4, index 1 = wrapping N=5.
  longint live [2][5][6];
  bit     lovf [2][5][6];
  longint shc  [2][5][6];
  bit     sho  [2][5][6];
  int     prev [2][5];
  bit     e_valid [2], e_err [2], e_ovf [2], e_any [2];
  longint e_data  [2];
  bit     mdl_on = 1'b0;

  function automatic void bump(input int d, input int p, input int c);
    if (live[d][p][c] == MAXV) begin
      lovf[d][p][c] = 1'b1;
      if (d == 1) live[d][p][c] = 0;
    end else begin
      live[d][p][c]++;
    end
  endfunction

  always @(posedge clk) begin : p_model
    int np, pr, s;
    bit any;
    for (int d = 0; d < 2; d++) begin
      np = (d == 0) ? 4 : 5;
      if (!rst_n) begin
        for (int p = 0; p < 5; p++) begin
          prev[d][p] = 0;
          for (int c = 0; c < 6; c++) begin
            live[d][p][c] = 0; lovf[d][p][c] = 0; shc[d][p][c] = 0; sho[d][p][c] = 0;
          end
        end
        e_valid[d] = 0; e_err[d] = 0; e_ovf[d] = 0; e_any[d] = 0; e_data[d] = 0;
      end else begin
        any = 0;
        for (int p = 0; p < np; p++)
          for (int c = 0; c < 6; c++) any |= lovf[d][p][c];
        pr = (d == 0) ? int'(rd_peri) % 4 : int'(rd_peri);
        e_valid[d] = rd_en;
        if (rd_en) begin
          if (pr >= np || rd_sel > 5) begin
            e_err[d] = 1; e_data[d] = 0; e_ovf[d] = 0;
          end else begin
            e_err[d] = 0; e_data[d] = shc[d][pr][rd_sel]; e_ovf[d] = sho[d][pr][rd_sel];
          end
        end
        e_any[d] = any;
        if (snap) begin
          shc[d] = live[d];
          sho[d] = lovf[d];
        end
        for (int p = 0; p < np; p++) begin
          s = (p < 4) ? int'(st[2*p +: 2]) : 0;
          if (clr) begin
            for (int c = 0; c < 6; c++) begin
              live[d][p][c] = 0; lovf[d][p][c] = 0;
            end
          end else if (en) begin
            bump(d, p, s);
            if (s == 2 && prev[d][p] != 2) bump(d, p, 4);
            if (s == 0 && prev[d][p] >= 2) bump(d, p, 5);
          end
          prev[d][p] = s;
        end
      end
    end
    if (!rst_n) mdl_on = 1'b1;
  end

  always @(negedge clk) begin
    if (mdl_on) begin
      check("A.rd_valid", a_rd_valid, e_valid[0]);
      check("A.rd_data",  a_rd_data,  e_data[0]);
      check("A.rd_ovf",   a_rd_ovf,   e_ovf[0]);
      check("A.rd_err",   a_rd_err,   e_err[0]);
      check("A.ovf_any",  a_ovf_any,  e_any[0]);
      check("B.rd_valid", b_rd_valid, e_valid[1]);
      check("B.rd_data",  b_rd_data,  e_data[1]);
      check("B.rd_ovf",   b_rd_ovf,   e_ovf[1]);
      check("B.rd_err",   b_rd_err,   e_err[1]);
      check("B.ovf_any",  b_ovf_any,  e_any[1]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic snap_now();
    snap = 1'b1;
    cyc();
    snap = 1'b0;
  endtask

  // One read, then literal checks on the response of both instances.
  task automatic rd_lit(input string nm, input int peri, input int sel,
                        input longint ea, input bit oa, input longint eb, input bit ob);
    rd_en = 1'b1; rd_peri = 3'(peri); rd_sel = 3'(sel);
    cyc();
    rd_en = 1'b0;
    @(negedge clk);
    check({nm, ".A.valid"}, a_rd_valid, 1);
    check({nm, ".A.data"},  a_rd_data,  ea);
    check({nm, ".A.ovf"},   a_rd_ovf,   oa);
    check({nm, ".B.data"},  b_rd_data,  eb);
    check({nm, ".B.ovf"},   b_rd_ovf,   ob);
  endtask

  int seq [7] = '{0, 2, 2, 1, 2, 3, 0};
  int exp_p1 [6] = '{2, 1, 3, 1, 2, 1};

  initial begin
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; snap = 1'b0; rd_en = 1'b0;
    st = 8'h00; rd_peri = '0; rd_sel = '0;
    cyc(); cyc();
    rst_n = 1'b1;

    // Long ACTIVE run on p0: saturates on A, wraps on B.
    st = 8'h54; en = 1'b1;
    repeat (257) cyc();
    en = 1'b0;
    snap_now();
    rd_lit("sat_act0", 0, 0, 255, 1, 1, 1);
    rd_lit("idle0",    0, 1, 0, 0, 0, 0);
    check("A.ovf_any_set", a_ovf_any, 1);
    check("B.ovf_any_set", b_ovf_any, 1);

    clr = 1'b1; cyc(); clr = 1'b0;
    snap_now();
    rd_lit("after_clr", 0, 0, 0, 0, 0, 0);
    check("A.ovf_any_clr", a_ovf_any, 0);

    // Transition sequence on p1.
    st = 8'h00; clr = 1'b1; cyc(); clr = 1'b0;
    en = 1'b1;
    for (int k = 0; k < 7; k++) begin
      st[3:2] = 2'(seq[k]);
      cyc();
    end
    en = 1'b0;
    snap_now();
    for (int c = 0; c < 6; c++) begin
      rd_lit($sformatf("p1_sel%0d", c), 1, c, exp_p1[c], 0, exp_p1[c], 0);
    end

    // Sleep entry while disabled must not be counted after re-enable.
    st[5:4] = 2'd2; cyc();
    en = 1'b1; cyc();
    en = 1'b0;
    snap_now();
    rd_lit("p2_entry", 2, 4, 0, 0, 0, 0);
    rd_lit("p2_sleep", 2, 2, 1, 0, 1, 0);

    // snap+clr together, with a read in the same cycle seeing the old shadow.
    clr = 1'b1; cyc(); clr = 1'b0;
    st[7:6] = 2'd1; en = 1'b1;
    repeat (10) cyc();
    en = 1'b0; snap = 1'b1; clr = 1'b1;
    rd_en = 1'b1; rd_peri = 3'd1; rd_sel = 3'd4;
    cyc();
    snap = 1'b0; clr = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    check("presnap.A", a_rd_data, 2);
    check("presnap.B", b_rd_data, 2);
    rd_lit("p3_idle10", 3, 1, 10, 0, 10, 0);
    en = 1'b1; cyc(); en = 1'b0;
    snap_now();
    rd_lit("p3_restart", 3, 1, 1, 0, 1, 0);

    // Out-of-range requests.
    rd_en = 1'b1; rd_peri = 3'd5; rd_sel = 3'd0;
    cyc();
    rd_en = 1'b0;
    @(negedge clk);
    check("B.err_peri.valid", b_rd_valid, 1);
    check("B.err_peri.err",   b_rd_err,   1);
    check("B.err_peri.data",  b_rd_data,  0);
    check("A.peri5_alias",    a_rd_err,   0);
    rd_en = 1'b1; rd_peri = 3'd0; rd_sel = 3'd6;
    cyc();
    rd_en = 1'b0;
    @(negedge clk);
    check("A.err_sel.err",  a_rd_err,  1);
    check("A.err_sel.data", a_rd_data, 0);
    check("A.err_sel.ovf",  a_rd_ovf,  0);

    // Back-to-back reads with a one-cycle reset in the middle.
    rd_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      rd_peri = 3'(k % 4); rd_sel = 3'(k % 6);
      rst_n = (k != 4);
      cyc();
      if (k == 4) begin
        @(negedge clk);
        check("rst.A.valid", a_rd_valid, 0);
        check("rst.A.data",  a_rd_data,  0);
        check("rst.B.valid", b_rd_valid, 0);
        check("rst.A.any",   a_ovf_any,  0);
      end
    end
    rst_n = 1'b1; rd_en = 1'b0;
    rd_lit("post_rst", 1, 4, 0, 0, 0, 0);
    repeat (3) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
